// File: rtl/store_rmw_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_rmw_ctrl_if : core store-request bundle and word-memory bus bundle |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

interface store_req_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] data;
  logic [2:0]  funct3;
  logic        done;
  logic        err;

  modport master (output valid, addr, data, funct3, input ready, done, err);
  modport slave  (input valid, addr, data, funct3, output ready, done, err);
endinterface

interface mem_bus_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/store_rmw_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_rmw_ctrl : SW direct write, SB/SH read-modify-write, with timeout  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module store_rmw_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  store_req_if.slave st,
  mem_bus_if.master  mem
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      addr_q;
  logic [15:0]      data_q;
  logic [31:0]      wdata_q;
  logic             is_half_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sw_ok;
  logic             rd_ok;
  logic [31:0]      merged;

  assign sw_ok = (st.funct3 == 3'b010) && (st.addr[1:0] == 2'b00);
  assign rd_ok = (st.funct3 == 3'b000) ||
                 ((st.funct3 == 3'b001) && !st.addr[0]);

  always_comb begin
    merged = mem.rdata;
    if (is_half_q) begin
      if (addr_q[1]) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else begin
      unique case (addr_q[1:0])
        2'b00:   merged[7:0]   = data_q[7:0];
        2'b01:   merged[15:8]  = data_q[7:0];
        2'b10:   merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (st.valid) state_nxt = sw_ok ? WR_REQ : (rd_ok ? RD_REQ : RESP);
      RD_REQ:  if (mem.gnt) state_nxt = RD_WAIT;
      // A response in the final waiting cycle still beats the timeout.
      RD_WAIT: if (mem.rvalid)            state_nxt = WR_REQ;
               else if (cnt_q == CNT_LAST) state_nxt = RESP;
      WR_REQ:  if (mem.gnt) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      data_q    <= '0;
      wdata_q   <= '0;
      is_half_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (st.valid) begin
            addr_q    <= st.addr;
            data_q    <= st.data[15:0];
            wdata_q   <= st.data;
            is_half_q <= st.funct3[0];
            err_q     <= !(sw_ok || rd_ok);
          end
        end
        RD_REQ: begin
          if (mem.gnt) cnt_q <= '0;
        end
        RD_WAIT: begin
          if (mem.rvalid) begin
            wdata_q <= merged;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign st.ready  = (state == IDLE);
  assign st.done   = (state == RESP);
  assign st.err    = (state == RESP) && err_q;
  assign mem.req   = (state == RD_REQ) || (state == WR_REQ);
  assign mem.we    = (state == WR_REQ);
  assign mem.addr  = {addr_q[31:2], 2'b00};
  assign mem.wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_store_rmw_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_store_rmw_ctrl : randomized store traffic against a byte-level model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module tb_store_rmw_ctrl;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  store_req_if st ();
  mem_bus_if   mem ();

  store_rmw_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .st      (st),
    .mem     (mem)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic err; int lat; int acc; } done_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  done_t       done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // memory responder configuration, set by the driver per store
  int          cfg_gnt_delay = 0;
  int          cfg_rv = 0;
  logic [31:0] cfg_rdata = '0;
  int          rd_cnt = 0;
  bit          rd_pend = 0;
  int          stall = 0;

  initial begin
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
    forever begin
      @(negedge clk);
      mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = $urandom;
      if (!reset_n) begin
        rd_pend = 0; stall = 0;
      end else begin
        if (rd_pend) begin
          if (rd_cnt == 0) begin
            mem.rvalid = 1'b1; mem.rdata = cfg_rdata; rd_pend = 0;
          end else rd_cnt--;
        end
        if (mem.req) begin
          // junk rvalid while a request is outstanding must be ignored
          if ($urandom_range(0, 3) == 0) mem.rvalid = 1'b1;
          if (stall < cfg_gnt_delay) stall++;
          else begin
            mem.gnt = 1'b1; stall = 0;
            if (!mem.we && cfg_rv >= 0) begin rd_pend = 1; rd_cnt = cfg_rv; end
          end
        end else stall = 0;
      end
    end
  end

  logic        p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  initial begin
    forever begin
      @(negedge clk); #2;
      if (!reset_n) begin p_req = 1'b0; continue; end
      if (mem.req) begin
        checks++;
        if (mem.addr[1:0] != 2'b00) begin
          errors++; $display("FAIL addr_align: got %h, required low bits 00", mem.addr);
        end
        if (p_req && !p_gnt) begin
          checks++;
          if (mem.we !== p_we || mem.addr !== p_addr || mem.wdata !== p_wdata) begin
            errors++;
            $display("FAIL stall_stable: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                     mem.we, mem.addr, mem.wdata, p_we, p_addr, p_wdata);
          end
        end
        if (mem.gnt) begin
          checks++;
          if (mem.we) begin
            if (wr_q.size() == 0) begin
              errors++; $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem.addr, mem.wdata);
            end else begin
              wr_t e;
              e = wr_q.pop_front();
              if (mem.addr !== e.addr || mem.wdata !== e.data) begin
                errors++;
                $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h", mem.addr, mem.wdata, e.addr, e.data);
              end
            end
          end else begin
            if (rd_q.size() == 0) begin
              errors++; $display("FAIL unexpected_read: got addr=%h, required no read", mem.addr);
            end else begin
              logic [31:0] ea;
              ea = rd_q.pop_front();
              if (mem.addr !== ea) begin
                errors++; $display("FAIL read_addr: got %h, required %h", mem.addr, ea);
              end
            end
          end
        end
      end
      if (st.done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++; $display("FAIL unexpected_done: got done=1 err=%b, required no done", st.err);
        end else begin
          done_t e;
          e = done_q.pop_front();
          if (st.err !== e.err || (cyc - e.acc) != e.lat || st.ready !== 1'b0) begin
            errors++;
            $display("FAIL done: got err=%b cycle=%0d ready=%b, required err=%b cycle=%0d ready=0",
                     st.err, cyc - e.acc, st.ready, e.err, e.lat);
          end
        end
      end
      p_req = mem.req; p_gnt = mem.gnt; p_we = mem.we; p_addr = mem.addr; p_wdata = mem.wdata;
    end
  end

  // Reference: decode by rule, merge as a byte array, latency by cycle budget per phase.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                          input int g, input int rv, input logic [31:0] rdat);
    int          off;
    bit          sw_ok, rd_ok;
    logic [7:0]  b [4];
    done_t       de;
    wr_t         we_;
    int          waited;
    off   = int'(a[1:0]);
    sw_ok = (f3 == 3'd2) && (off == 0);
    rd_ok = (f3 == 3'd0) || ((f3 == 3'd1) && (off % 2 == 0));
    cfg_gnt_delay = g; cfg_rv = rv; cfg_rdata = rdat;
    de.acc = cyc;
    if (sw_ok) begin
      we_.addr = a & ~32'd3; we_.data = d; wr_q.push_back(we_);
      de.err = 1'b0; de.lat = 2 + g;
    end else if (rd_ok) begin
      rd_q.push_back(a & ~32'd3);
      if (rv >= 0 && rv < TO) begin
        for (int i = 0; i < 4; i++) b[i] = rdat[8*i +: 8];
        b[off] = d[7:0];
        if (f3 == 3'd1) b[off+1] = d[15:8];
        we_.addr = a & ~32'd3; we_.data = {b[3], b[2], b[1], b[0]}; wr_q.push_back(we_);
        de.err = 1'b0; de.lat = 4 + 2*g + rv;
      end else begin
        de.err = 1'b1; de.lat = 2 + g + TO;
      end
    end else begin
      de.err = 1'b1; de.lat = 1;
    end
    done_q.push_back(de);
    st.valid = 1'b1; st.addr = a; st.data = d; st.funct3 = f3;
    @(negedge clk);
    st.valid = 1'b0; st.addr = $urandom; st.data = $urandom; st.funct3 = 3'($urandom);
    waited = 0;
    while (!st.ready && waited < 400) begin @(negedge clk); waited++; end
    checks++;
    if (!st.ready) begin
      errors++; $display("FAIL ready_timeout: got ready=0 after %0d cycles, required ready=1", waited);
    end else if (cyc - de.acc != de.lat + 1) begin
      errors++; $display("FAIL ready_return: got cycle %0d, required cycle %0d", cyc - de.acc, de.lat + 1);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          r, g, rv;
    logic [2:0]  f3;
    logic [31:0] a;
    st.valid = 1'b0; st.addr = '0; st.data = '0; st.funct3 = '0;
    #12;
    chk("rst_ready", 32'(st.ready), 32'd1);
    chk("rst_done_err", {30'd0, st.done, st.err}, 32'd0);
    chk("rst_req_we", {30'd0, mem.req, mem.we}, 32'd0);
    chk("rst_addr", mem.addr, 32'd0);
    chk("rst_wdata", mem.wdata, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    do_store(32'h100, 32'hDEADBEEF, 3'd2, 0, 0, '0);
    for (int o = 0; o < 4; o++) do_store(32'h100 + 32'(o), 32'h00000011, 3'd0, 0, 0, 32'hAABBCCDD);
    do_store(32'h202, 32'h00001234, 3'd1, 0, 0, 32'hAABBCCDD);
    do_store(32'h200, 32'h00001234, 3'd1, 0, 0, 32'hAABBCCDD);
    do_store(32'h201, 32'h00001234, 3'd1, 0, 0, '0);
    do_store(32'h302, 32'h12345678, 3'd2, 0, 0, '0);
    do_store(32'h400, 32'h12345678, 3'd3, 0, 0, '0);
    do_store(32'h500, 32'h000000A5, 3'd0, 5, -1, 32'h01234567);
    do_store(32'h600, 32'h0000BEEF, 3'd1, 1, TO - 1, 32'hCAFEF00D);
    do_store(32'h703, 32'h0000005A, 3'd0, 0, TO, 32'h13572468);

    // reset while a write request is stalled
    cfg_gnt_delay = 40;
    st.valid = 1'b1; st.addr = 32'h800; st.data = 32'h55AA55AA; st.funct3 = 3'd2;
    @(negedge clk); st.valid = 1'b0;
    chk("pre_rst_wr_req", {30'd0, mem.req, mem.we}, 32'd3);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", {30'd0, mem.req, st.done}, 32'd0);
    chk("mid_rst_ready", 32'(st.ready), 32'd1);
    chk("mid_rst_wdata", mem.wdata, 32'd0);
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    chk("post_rst_ready", 32'(st.ready), 32'd1);
    do_store(32'h900, 32'h0BADF00D, 3'd2, 1, 0, '0);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      f3 = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 8) ? 3'd2 : (r == 8) ? 3'd3 : 3'($urandom_range(3, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      g  = $urandom_range(0, 3);
      rv = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 6);
      do_store(a, $urandom, f3, g, rv, $urandom);
    end

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(wr_q.size() + rd_q.size() + done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
- Multi-cycle store sequencer between the core's store path and a single-ported, word-wide data memory that has no byte enables.
- SW is written directly to memory.
- SB and SH use read-modify-write: read the word, merge the byte or halfword at the address offset, write the word back.
- Misaligned or unsupported stores are rejected without touching memory. A read-response timeout stops the block hanging on a dead memory.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in RD_WAIT before aborting with error (must be >= 1).
- CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  controller can accept a request
- st_addr  in  32  byte address
- st_data  in  32  rs2 data
- st_funct3  in  3  000 SB, 001 SH, 010 SW
- st_done  out  1  one-cycle completion pulse
- st_err  out  1  valid with st_done; 1 = rejected or aborted
- mem_req  out  1  memory request
- mem_we  out  1  1 write, 0 read
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  write word
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, counter=0.
  - st_ready=1; st_done, st_err, mem_req, mem_we = 0; mem_addr and mem_wdata = 0.
  - mem_req drops immediately, even mid-transaction. The pending store is discarded with no st_done.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP. All outputs are decoded from registered state and data only (Moore).
- IDLE:
  - st_ready=1.
  - On st_valid: capture addr, data and funct3 into registers, then decode:
    - 010 with addr[1:0]==0 -> WR_REQ, write word = st_data.
    - 000 (any offset), or 001 with addr[0]==0 -> RD_REQ.
    - Anything else (misaligned SH/SW, funct3 not in {000,001,010}) -> RESP with error flag set. No memory access occurs.
- RD_REQ:
  - mem_req=1, mem_we=0, mem_addr = word address.
  - Hold until mem_gnt, then go to RD_WAIT with counter cleared.
- RD_WAIT:
  - mem_req=0.
  - On mem_rvalid: register the merged word, then go to WR_REQ. Merge rules:
    - SB: insert data[7:0] at byte addr[1:0].
    - SH: insert data[15:0] at the upper half if addr[1]=1, else the lower half.
    - All other bits come from mem_rdata.
  - Otherwise increment counter. When counter == TIMEOUT_CYCLES-1 and rvalid is absent, go to RESP with error; no write occurs.
  - rvalid wins over timeout in the same cycle.
- WR_REQ:
  - mem_req=1, mem_we=1, mem_addr = word address, mem_wdata = merged word.
  - Hold until mem_gnt, then go to RESP with no error.
- RESP:
  - st_done=1 for exactly one cycle; st_err = error flag.
  - st_ready=0. Next state is IDLE.
- st_ready=0 in every state except IDLE, so there is no back-to-back accept during RESP.
- mem_rvalid is ignored outside RD_WAIT. mem_gnt is ignored when mem_req=0.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_gnt=0.
- Latency with mem_gnt and mem_rvalid asserted the cycle after the request, counting the accept cycle as 0:
  - SW: done in cycle 2.
  - SB/SH: RD_REQ 1, RD_WAIT 2, WR_REQ 3, done in cycle 4.
  - Error decode: done in cycle 1.
- Widths: counter is CNT_W bits and saturation-free, since it is cleared on RD_WAIT entry. Address bits [1:0] on mem_addr are always 0.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt immediate -> one write: mem_addr 0x100, mem_wdata 0xDEADBEEF, we=1. No read issued. st_done=1, st_err=0 in cycle 2.
- SB addr 0x102, data 0x00000011, mem_rdata 0xAABBCCDD -> read at 0x100, then write 0xAA11CCDD. Also cover offsets 0/1/3: 0xAABBCC11, 0xAABB11DD, 0x11BBCCDD.
- SH addr 0x202, data 0x00001234, rdata 0xAABBCCDD -> write 0x1234CCDD. SH addr 0x200 -> 0xAABB1234.
- SH addr 0x201, SW addr 0x302, and funct3 011 -> mem_req stays 0 throughout; st_done=st_err=1 in cycle 1; st_ready back to 1 in cycle 2.
- SB with gnt held low 5 cycles -> mem_addr and mem_we stable during the stall. mem_rvalid then never arrives -> st_done=st_err=1 after exactly 16 RD_WAIT cycles, and no write request is ever issued.
- Assert reset_n=0 while in WR_REQ -> mem_req=0 immediately, no st_done. After release: st_ready=1 and a new SW completes normally.
